// File: rtl/regfile_arb_pkg.sv
// Shared widths and write-request bundle for the
// SIMD register file write-port arbiter.
package regfile_arb_pkg;

    localparam int RF_NUM_REQ = 4;
    localparam int RF_DEPTH   = 16;
    localparam int RF_BITS    = 32;
    localparam int RF_AW      = $clog2(RF_DEPTH);
    localparam int RF_GW      = $clog2(RF_NUM_REQ);

    typedef struct packed {
        logic [RF_AW-1:0]   addr;
        logic [RF_BITS-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Grant selection and rotating pointer.
// REGFILE_ARB_FIXED_PRIORITY_EN: lowest index wins, no pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN

    logic unused_sigs;
    assign unused_sigs = ^{clk, rst_n, advance};

    // Lowest-index valid requester wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && !hold && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

`else

    logic [IW-1:0] rr_ptr;

    // Scan from rr_ptr upward, wrapping, first valid wins.
    always_comb begin
        logic          found;
        int            s;
        logic [IW-1:0] idx;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        s       = 0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = IW'(s);
            if (!found && !hold && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    // Pointer moves past the winner only when a transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            if (gnt_idx == IW'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_idx + IW'(1);
        end
    end

`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port among NUM_REQ producers.
// Option: REGFILE_ARB_FIXED_PRIORITY_EN (see rr_arbiter).
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int DEPTH   = RF_DEPTH,
    parameter int BITS    = RF_BITS,
    parameter int AW      = $clog2(DEPTH),
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][AW-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][BITS-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [AW-1:0]                 wr_addr,
    output logic [BITS-1:0]               wr_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    logic [NUM_REQ-1:0] gnt;
    logic [GW-1:0]      gnt_idx;
    logic               xfer;
    logic [AW-1:0]      sel_addr;
    logic [BITS-1:0]    sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (GW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .hold    (hold),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |(req_valid & gnt);
    assign sel_addr  = req_addr[gnt_idx];
    assign sel_data  = req_data[gnt_idx];
    assign busy      = (|req_valid) | wr_en;

    // Register the winner onto the port; R0 writes never raise wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            wr_en <= xfer && (sel_addr != '0);
            if (xfer) begin
                wr_addr  <= sel_addr;
                wr_data  <= sel_data;
                grant_id <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// Honours REGFILE_ARB_FIXED_PRIORITY_EN.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    typedef struct packed {
        logic       xfer;
        logic       en;
        logic [1:0] id;
        rf_wr_req_t w;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            hold;
    logic [3:0]      req_valid;
    logic [3:0][3:0] req_addr;
    logic [3:0][31:0] req_data;
    logic [3:0]      req_ready;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [31:0]     wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int         n_chk;
    int         n_err;
    int         pulses;
    logic [1:0] mptr;
    logic       last_en;
    logic [31:0] rf [16];
    exp_t       sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model fed by the write port.
    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
        if (wr_en) pulses <= pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, need %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_rdy(
        input logic [3:0] v,
        input logic       h,
        input logic [1:0] p
    );
        logic [3:0] r;
        int         ix;
        r = '0;
        if (!h) begin
            for (int k = 3; k >= 0; k--) begin
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
                ix = k;
`else
                ix = (int'(p) + k) % 4;
`endif
                if (v[ix]) r = 4'(1 << ix);
            end
        end
        return r;
    endfunction

    // One clock: check grant, push expectation, pop at output.
    task automatic step(input bit keep, output logic [3:0] got);
        logic [3:0] er;
        exp_t       e;
        int         idx;
        er = model_rdy(req_valid, hold, mptr);
        @(negedge clk);
        got = req_ready;
        chk("ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'((|req_valid) | last_en));
        e   = '0;
        idx = -1;
        for (int k = 0; k < 4; k++) if (er[k]) idx = k;
        if (idx >= 0) begin
            e.xfer   = 1'b1;
            e.id     = 2'(idx);
            e.w.addr = req_addr[idx];
            e.w.data = req_data[idx];
            e.en     = (req_addr[idx] != 4'd0);
            mptr     = (idx == 3) ? 2'd0 : 2'(idx + 1);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.en));
        last_en = e.en;
        if (e.xfer) begin
            chk("wr_addr", 32'(wr_addr), 32'(e.w.addr));
            chk("wr_data", wr_data, e.w.data);
            chk("grant_id", 32'(grant_id), 32'(e.id));
        end
        if (!keep) req_valid = req_valid & ~er;
    endtask

    logic [3:0] g;
    int         p0;

    initial begin
        n_chk     = 0;
        n_err     = 0;
        pulses    = 0;
        mptr      = 2'd0;
        last_en   = 1'b0;
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        #3;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset drops an active write without a clock edge.
        req_valid   = 4'b0010;
        req_addr[1] = 4'd5;
        req_data[1] = 32'h0000_0055;
        step(1'b0, g);
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        mptr    = 2'd0;
        last_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four valid: grants 0,1,2,3 from a fresh pointer.
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 4'(i + 1);
            req_data[i] = 32'h0000_00A0 + 32'(i);
        end
        req_valid = 4'b1111;
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, g);
            chk($sformatf("seq_gid%0d", i), 32'(grant_id), 32'(i));
        end
        step(1'b0, g);
        chk("pulse_count", 32'(pulses - p0), 32'd4);
        for (int i = 1; i <= 4; i++)
            chk($sformatf("rf_r%0d", i), rf[i], 32'h0000_009F + 32'(i));

        // R0 write is accepted but never reaches the regfile.
        req_addr[2] = 4'd0;
        req_data[2] = 32'hFFFF_FFFF;
        req_valid   = 4'b0100;
        step(1'b0, g);
        chk("r0_ready", 32'(g), 32'h4);
        chk("r0_gid", 32'(grant_id), 32'd2);
        chk("r0_wr_addr", 32'(wr_addr), 32'd0);
        step(1'b0, g);
        chk("r0_rf", rf[0], 32'd0);

        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 4'(i + 8);
            req_data[i] = 32'hC0DE_0000 + 32'(i);
        end

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
        // Lowest index starves the highest one.
        req_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, g);
            chk($sformatf("fp_ready%0d", i), 32'(g), 32'h1);
            chk($sformatf("fp_gid%0d", i), 32'(grant_id), 32'd0);
        end
        req_valid = '0;
        step(1'b0, g);
`else
        // Bring pointer to 2, then 3 before 1 with wrap.
        req_valid = 4'b0010;
        step(1'b0, g);
        chk("ptr_setup_gid", 32'(grant_id), 32'd1);
        req_valid = 4'b1010;
        step(1'b0, g);
        chk("wrap_gid_a", 32'(grant_id), 32'd3);
        step(1'b0, g);
        chk("wrap_gid_b", 32'(grant_id), 32'd1);
        req_valid = 4'b1111;
        step(1'b1, g);
        chk("ptr2_gid", 32'(grant_id), 32'd2);

        // Hold freezes grants and pointer; write in flight finishes.
        chk("hold_inflight", 32'(wr_en), 32'd1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, g);
            chk($sformatf("hold_ready%0d", i), 32'(g), 32'd0);
        end
        hold = 1'b0;
        step(1'b1, g);
        chk("resume_gid", 32'(grant_id), 32'd3);
        step(1'b1, g);
        chk("resume_gid2", 32'(grant_id), 32'd0);
        req_valid = '0;
        step(1'b0, g);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
